// File: rtl/alu_decode_stage.sv
// alu_decode_stage: MIPS-subset decoder feeding an ALU through one valid/ready register stage.
// Rev 1.0 -- initial release.
`default_nettype none

module alu_decode_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      X,
  output logic [31:0]      Y,
  output logic [2:0]       ALUctr,
  output logic [4:0]       wr_reg,
  output logic             wr_en,
  output logic             ill_instr,
  output logic [CNT_W-1:0] ill_count
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ADDIU = 6'h09;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_SLTIU = 6'h0B;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;

  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_ADDU  = 6'h21;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_SUBU  = 6'h23;
  localparam logic [5:0] c_FN_OR    = 6'h25;
  localparam logic [5:0] c_FN_SLT   = 6'h2A;
  localparam logic [5:0] c_FN_SLTU  = 6'h2B;

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic [2:0]       ctr_q, ctr_d;
  logic [4:0]       wr_reg_q, wr_reg_d;
  logic             wr_en_q, wr_en_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        w_accept;
  logic        w_nop;
  logic        w_legal;
  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_x, w_y;
  logic [2:0]  w_ctr;
  logic [4:0]  w_wr;
  logic        w_wr_en;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_imm    = instr[15:0];
  assign w_nop    = (instr == 32'h0);

  assign in_ready = ~out_valid_q | out_ready;
  assign w_accept = in_valid & in_ready & ~flush;

  always_comb begin
    w_x     = rs_data;
    w_y     = {{16{w_imm[15]}}, w_imm};
    w_ctr   = 3'b000;
    w_wr    = instr[20:16];
    w_legal = 1'b1;
    if (w_nop) begin
      w_x  = 32'h0;
      w_y  = 32'h0;
      w_wr = 5'd0;
    end else begin
      unique case (w_opcode)
        c_OP_RTYPE: begin
          w_y  = rt_data;
          w_wr = instr[15:11];
          unique case (w_funct)
            c_FN_ADDU: w_ctr = 3'b000;
            c_FN_ADD:  w_ctr = 3'b001;
            c_FN_SUBU: w_ctr = 3'b100;
            c_FN_SUB:  w_ctr = 3'b101;
            c_FN_OR:   w_ctr = 3'b010;
            c_FN_SLT:  w_ctr = 3'b111;
            c_FN_SLTU: w_ctr = 3'b110;
            default:   w_legal = 1'b0;
          endcase
        end
        c_OP_ADDIU: w_ctr = 3'b000;
        c_OP_ADDI:  w_ctr = 3'b001;
        c_OP_SLTI:  w_ctr = 3'b111;
        c_OP_SLTIU: w_ctr = 3'b110;
        c_OP_ORI: begin
          w_ctr = 3'b010;
          w_y   = {16'h0, w_imm};
        end
        c_OP_LUI: begin
          w_ctr = 3'b010;
          w_x   = 32'h0;
          w_y   = {w_imm, 16'h0};
        end
        default: w_legal = 1'b0;
      endcase
    end
    // Illegal words still travel down the pipe, but as an inert no-write bubble.
    if (!w_legal) begin
      w_x   = 32'h0;
      w_y   = 32'h0;
      w_ctr = 3'b000;
      w_wr  = 5'd0;
    end
  end

  assign w_wr_en = w_legal & ~w_nop & (w_wr != 5'd0);

  always_comb begin
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    ctr_d       = ctr_q;
    wr_reg_d    = wr_reg_q;
    wr_en_d     = wr_en_q;
    ill_d       = ill_q;
    cnt_d       = cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d = 1'b1;
      x_d         = w_x;
      y_d         = w_y;
      ctr_d       = w_ctr;
      wr_reg_d    = w_wr;
      wr_en_d     = w_wr_en;
      ill_d       = ~w_legal;
      if (!w_legal && cnt_q != c_CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      x_q         <= 32'h0;
      y_q         <= 32'h0;
      ctr_q       <= 3'b000;
      wr_reg_q    <= 5'd0;
      wr_en_q     <= 1'b0;
      ill_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ctr_q       <= ctr_d;
      wr_reg_q    <= wr_reg_d;
      wr_en_q     <= wr_en_d;
      ill_q       <= ill_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign X         = x_q;
  assign Y         = y_q;
  assign ALUctr    = ctr_q;
  assign wr_reg    = wr_reg_q;
  assign wr_en     = wr_en_q;
  assign ill_instr = ill_q;
  assign ill_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: table-driven decode vectors plus directed stall/flush/saturation/reset sequences.
// Rev 1.0 -- initial release.
`default_nettype none

module tb_alu_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic [2:0]  ALUctr;
  logic [4:0]  wr_reg;
  logic        wr_en;
  logic        ill_instr;
  logic [7:0]  ill_count;

  int errors = 0;
  int checks = 0;

  alu_decode_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .X(X), .Y(Y),
    .ALUctr(ALUctr), .wr_reg(wr_reg), .wr_en(wr_en),
    .ill_instr(ill_instr), .ill_count(ill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  ctr;
    logic [4:0]  wr;
    logic        en;
    logic        ill;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    instr     = ins;
    rs_data   = rs;
    rt_data   = rt;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  int exp_cnt;

  initial begin
    vecs[0]  = '{32'h00221820, 32'd5,  32'd7, 32'd5,  32'd7,        3'b001, 5'd3, 1'b1, 1'b0}; // add
    vecs[1]  = '{32'h2022FFFF, 32'd10, 32'd0, 32'd10, 32'hFFFFFFFF, 3'b001, 5'd2, 1'b1, 1'b0}; // addi
    vecs[2]  = '{32'h34048000, 32'd3,  32'd9, 32'd3,  32'h00008000, 3'b010, 5'd4, 1'b1, 1'b0}; // ori
    vecs[3]  = '{32'h3C051234, 32'd77, 32'd9, 32'd0,  32'h12340000, 3'b010, 5'd5, 1'b1, 1'b0}; // lui
    vecs[4]  = '{32'h00221821, 32'd5,  32'd7, 32'd5,  32'd7,        3'b000, 5'd3, 1'b1, 1'b0}; // addu
    vecs[5]  = '{32'h00221823, 32'd5,  32'd7, 32'd5,  32'd7,        3'b100, 5'd3, 1'b1, 1'b0}; // subu
    vecs[6]  = '{32'h00221822, 32'd5,  32'd7, 32'd5,  32'd7,        3'b101, 5'd3, 1'b1, 1'b0}; // sub
    vecs[7]  = '{32'h00221825, 32'd5,  32'd7, 32'd5,  32'd7,        3'b010, 5'd3, 1'b1, 1'b0}; // or
    vecs[8]  = '{32'h0022182A, 32'd5,  32'd7, 32'd5,  32'd7,        3'b111, 5'd3, 1'b1, 1'b0}; // slt
    vecs[9]  = '{32'h0022182B, 32'd5,  32'd7, 32'd5,  32'd7,        3'b110, 5'd3, 1'b1, 1'b0}; // sltu
    vecs[10] = '{32'h24230005, 32'd8,  32'd1, 32'd8,  32'h00000005, 3'b000, 5'd3, 1'b1, 1'b0}; // addiu
    vecs[11] = '{32'h2823FFFE, 32'd8,  32'd1, 32'd8,  32'hFFFFFFFE, 3'b111, 5'd3, 1'b1, 1'b0}; // slti
    vecs[12] = '{32'h2C230001, 32'd8,  32'd1, 32'd8,  32'h00000001, 3'b110, 5'd3, 1'b1, 1'b0}; // sltiu
    vecs[13] = '{32'h00220021, 32'd5,  32'd7, 32'd5,  32'd7,        3'b000, 5'd0, 1'b0, 1'b0}; // addu -> $0
    vecs[14] = '{32'h00000000, 32'd5,  32'd7, 32'd0,  32'd0,        3'b000, 5'd0, 1'b0, 1'b0}; // nop
    vecs[15] = '{32'hFC000000, 32'd5,  32'd7, 32'd0,  32'd0,        3'b000, 5'd0, 1'b0, 1'b1}; // illegal

    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_ill_count", {24'd0, ill_count}, 32'd0);
    check("rst_X",         X,                  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt, 1'b1, 1'b0);
      if (vecs[i].ill) exp_cnt++;
      check($sformatf("v%0d_valid", i),  {31'd0, out_valid},    32'd1);
      check($sformatf("v%0d_X", i),      X,                     vecs[i].x);
      check($sformatf("v%0d_Y", i),      Y,                     vecs[i].y);
      check($sformatf("v%0d_ctr", i),    {29'd0, ALUctr},       {29'd0, vecs[i].ctr});
      check($sformatf("v%0d_wr", i),     {27'd0, wr_reg},       {27'd0, vecs[i].wr});
      check($sformatf("v%0d_en", i),     {31'd0, wr_en},        {31'd0, vecs[i].en});
      check($sformatf("v%0d_ill", i),    {31'd0, ill_instr},    {31'd0, vecs[i].ill});
      check($sformatf("v%0d_cnt", i),    {24'd0, ill_count},    exp_cnt);
    end

    // Illegal R-type funct (0x24) also counts.
    drive(1'b1, 32'h00221824, 32'd5, 32'd7, 1'b1, 1'b0);
    exp_cnt++;
    check("rand_ill",   {31'd0, ill_instr}, 32'd1);
    check("rand_X",     X,                  32'd0);
    check("rand_cnt",   {24'd0, ill_count}, exp_cnt);

    // Stall: hold add while ori waits upstream.
    drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h34048000, 32'd3, 32'd9, 1'b0, 1'b0);
      check($sformatf("stall%0d_in_ready", c), {31'd0, in_ready},  32'd0);
      check($sformatf("stall%0d_valid", c),    {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d_X", c),        X,                  32'd5);
      check($sformatf("stall%0d_Y", c),        Y,                  32'd7);
      check($sformatf("stall%0d_ctr", c),      {29'd0, ALUctr},    32'd1);
      check($sformatf("stall%0d_wr", c),       {27'd0, wr_reg},    32'd3);
    end
    drive(1'b1, 32'h34048000, 32'd3, 32'd9, 1'b1, 1'b0);
    check("unstall_valid", {31'd0, out_valid}, 32'd1);
    check("unstall_Y",     Y,                  32'h00008000);
    check("unstall_ctr",   {29'd0, ALUctr},    32'd2);
    check("unstall_wr",    {27'd0, wr_reg},    32'd4);
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("drain_valid",   {31'd0, out_valid}, 32'd0);
    check("drain_in_ready",{31'd0, in_ready},  32'd1);

    // Flush against a held instruction with an illegal word incoming.
    drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b0);
    check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 32'hFC000000, 32'd0, 32'd0, 1'b1, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_cnt",   {24'd0, ill_count}, exp_cnt);
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("post_flush_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 32'hFC000000, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b0, 1'b0);
    check("prerst_cnt", {24'd0, ill_count}, exp_cnt + 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid",    {31'd0, out_valid}, 32'd0);
    check("midrst_cnt",      {24'd0, ill_count}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready},  32'd1);
    check("midrst_ill",      {31'd0, ill_instr}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("no_reissue_valid", {31'd0, out_valid}, 32'd0);

    // Saturation: 300 illegal words with one NOP in between.
    for (int k = 0; k < 100; k++) drive(1'b1, 32'hFC000000, 32'd0, 32'd0, 1'b1, 1'b0);
    check("sat100_cnt", {24'd0, ill_count}, 32'd100);
    drive(1'b1, 32'h00000000, 32'd1, 32'd1, 1'b1, 1'b0);
    check("nop_cnt", {24'd0, ill_count}, 32'd100);
    check("nop_ill", {31'd0, ill_instr}, 32'd0);
    for (int k = 0; k < 200; k++) drive(1'b1, 32'hFC000000, 32'd0, 32'd0, 1'b1, 1'b0);
    check("sat_cnt",   {24'd0, ill_count}, 32'd255);
    check("sat_ill",   {31'd0, ill_instr}, 32'd1);
    check("sat_wr_en", {31'd0, wr_en},     32'd0);
    check("sat_valid", {31'd0, out_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
